// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned ZERO_REG   = 0;

    // Stall-depth encoding held in the 2-bit stall_left counter
    localparam int unsigned STALL_W = 2;
    localparam logic [STALL_W-1:0] STALL_NONE    = 2'd0;
    localparam logic [STALL_W-1:0] STALL_ONE     = 2'd1;
    localparam logic [STALL_W-1:0] STALL_LOAD_BR = 2'd2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard information from the pipeline and the control pins driven back into it.
interface hazard_ctrl_unit_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [REG_AW-1:0] rs_id;
    logic [REG_AW-1:0] rt_id;
    logic              use_rs;
    logic              use_rt;
    logic              is_branch_id;
    logic              br_taken_id;
    logic              jump_id;
    logic [REG_AW-1:0] rd_ex;
    logic              regwrite_ex;
    logic              memread_ex;
    logic [REG_AW-1:0] rd_mem;
    logic              memread_mem;
    logic              mem_req;
    logic              mem_ready;

    logic              pc_en;
    logic              if2id_en;
    logic              id2ex_en;
    logic              ex2mem_en;
    logic              mem2wb_en;
    logic              if2id_flush;
    logic              id2ex_flush;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_cycles;

    modport master (
        output rs_id, rt_id, use_rs, use_rt, is_branch_id, br_taken_id, jump_id,
               rd_ex, regwrite_ex, memread_ex, rd_mem, memread_mem, mem_req, mem_ready,
        input  pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en, if2id_flush, id2ex_flush,
               stall_cycles, flush_cycles
    );

    modport slave (
        input  rs_id, rt_id, use_rs, use_rt, is_branch_id, br_taken_id, jump_id,
               rd_ex, regwrite_ex, memread_ex, rd_mem, memread_mem, mem_req, mem_ready,
        output pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en, if2id_flush, id2ex_flush,
               stall_cycles, flush_cycles
    );

endinterface

// File: rtl/hazard_match.sv
// Destination-vs-source register compare for one downstream stage; $0 never matches.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              use_rs,
    input  logic              use_rt,
    output logic              hit_c
);

    assign hit_c = (rd != REG_AW'(ZERO_REG)) &&
                   ((use_rs && (rd == rs)) || (use_rt && (rd == rt)));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush sequencer for the 5-stage pipeline with saturating stall/flush cycle counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst,
    hazard_ctrl_unit_if.slave bus
);

    state_t               state, state_n, ret_state, ret_state_n, eff_state;
    logic [STALL_W-1:0]   stall_left, stall_left_n, need;
    logic                 hit_ex, hit_mem, mem_wait, freeze, stall_c, flush_c;
    logic [CNT_W-1:0]     stall_cnt, flush_cnt;

    hazard_match #(.REG_AW(REG_AW)) u_match_ex (
        .rd(bus.rd_ex), .rs(bus.rs_id), .rt(bus.rt_id),
        .use_rs(bus.use_rs), .use_rt(bus.use_rt), .hit_c(hit_ex)
    );

    hazard_match #(.REG_AW(REG_AW)) u_match_mem (
        .rd(bus.rd_mem), .rs(bus.rs_id), .rt(bus.rt_id),
        .use_rs(bus.use_rs), .use_rt(bus.use_rt), .hit_c(hit_mem)
    );

    assign mem_wait = bus.mem_req && !bus.mem_ready;

    // Stall depth required by the instruction currently in ID
    always_comb begin
        need = STALL_NONE;
        if (bus.memread_ex && hit_ex)
            need = bus.is_branch_id ? STALL_LOAD_BR : STALL_ONE;
        else if (bus.regwrite_ex && hit_ex && bus.is_branch_id)
            need = STALL_ONE;
        else if (bus.memread_mem && hit_mem && bus.is_branch_id)
            need = STALL_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            ret_state  <= RUN;
            stall_left <= STALL_NONE;
        end else begin
            state      <= state_n;
            ret_state  <= ret_state_n;
            stall_left <= stall_left_n;
        end
    end

    // The cycle memory becomes ready behaves exactly as the interrupted state
    always_comb begin
        state_n      = state;
        ret_state_n  = ret_state;
        stall_left_n = stall_left;
        freeze       = 1'b0;
        stall_c      = 1'b0;
        flush_c      = 1'b0;
        eff_state    = (state == MEM_WAIT) ? ret_state : state;
        if (mem_wait) begin
            freeze      = 1'b1;
            state_n     = MEM_WAIT;
            ret_state_n = eff_state;
        end else begin
            case (eff_state)
                STALL: begin
                    stall_c = 1'b1;
                    if (stall_left <= STALL_ONE) begin
                        state_n      = RUN;
                        stall_left_n = STALL_NONE;
                    end else begin
                        state_n      = STALL;
                        stall_left_n = stall_left - STALL_ONE;
                    end
                end
                default: begin
                    state_n = RUN;
                    if (need != STALL_NONE) begin
                        stall_c      = 1'b1;
                        stall_left_n = need - STALL_ONE;
                        state_n      = (need > STALL_ONE) ? STALL : RUN;
                    end else if ((bus.is_branch_id && bus.br_taken_id) || bus.jump_id) begin
                        flush_c = 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.pc_en        = !(freeze || stall_c);
    assign bus.if2id_en     = !(freeze || stall_c);
    assign bus.id2ex_en     = !freeze;
    assign bus.ex2mem_en    = !freeze;
    assign bus.mem2wb_en    = !freeze;
    assign bus.if2id_flush  = flush_c;
    assign bus.id2ex_flush  = stall_c;
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_cycles = flush_cnt;

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((freeze || stall_c) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_c && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit, including a narrow-counter saturation instance.
module tb_hazard_ctrl_unit;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    // {pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en, if2id_flush, id2ex_flush}
    localparam logic [6:0] RUNV    = 7'b1111100;
    localparam logic [6:0] STALLV  = 7'b0011101;
    localparam logic [6:0] FLUSHV  = 7'b1111110;
    localparam logic [6:0] FREEZEV = 7'b0000000;

    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(16)) hif ();
    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(2))  hsat ();

    hazard_ctrl_unit #(.REG_AW(5), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(hif));
    hazard_ctrl_unit #(.REG_AW(5), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(hsat));

    logic [6:0] ctl;
    assign ctl = {hif.pc_en, hif.if2id_en, hif.id2ex_en, hif.ex2mem_en, hif.mem2wb_en,
                  hif.if2id_flush, hif.id2ex_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        hif.rs_id = 5'd0; hif.rt_id = 5'd0; hif.use_rs = 1'b0; hif.use_rt = 1'b0;
        hif.is_branch_id = 1'b0; hif.br_taken_id = 1'b0; hif.jump_id = 1'b0;
        hif.rd_ex = 5'd0; hif.regwrite_ex = 1'b0; hif.memread_ex = 1'b0;
        hif.rd_mem = 5'd0; hif.memread_mem = 1'b0; hif.mem_req = 1'b0; hif.mem_ready = 1'b0;
        hsat.rs_id = 5'd0; hsat.rt_id = 5'd0; hsat.use_rs = 1'b0; hsat.use_rt = 1'b0;
        hsat.is_branch_id = 1'b0; hsat.br_taken_id = 1'b0; hsat.jump_id = 1'b0;
        hsat.rd_ex = 5'd0; hsat.regwrite_ex = 1'b0; hsat.memread_ex = 1'b0;
        hsat.rd_mem = 5'd0; hsat.memread_mem = 1'b0; hsat.mem_req = 1'b0; hsat.mem_ready = 1'b0;
    endtask

    // Leaves the bench just after a falling edge with reset released
    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // lw $2 in EX, ID reads $2 and $3
    task automatic set_lw2_in_ex(input logic branch);
        hif.rd_ex = 5'd2; hif.memread_ex = 1'b1; hif.regwrite_ex = 1'b1;
        hif.rs_id = 5'd2; hif.use_rs = 1'b1; hif.rt_id = 5'd3; hif.use_rt = 1'b1;
        hif.is_branch_id = branch;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #1;
        vectors++;
        if (ctl !== RUNV) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, RUNV); end
        vectors++;
        if (hif.stall_cycles !== 16'd0 || hif.flush_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hif.stall_cycles, hif.flush_cycles);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (ctl !== RUNV) begin errors++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, RUNV); end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        do_reset();
        set_lw2_in_ex(1'b0);
        #1;
        vectors++;
        if (ctl !== STALLV) begin errors++; $display("FAIL load_use_stall got=%b exp=%b", ctl, STALLV); end
        @(negedge clk);
        hif.rd_ex = 5'd0; hif.memread_ex = 1'b0; hif.regwrite_ex = 1'b0;
        hif.rd_mem = 5'd2; hif.memread_mem = 1'b1;
        #1;
        vectors++;
        if (ctl !== RUNV) begin errors++; $display("FAIL load_use_release got=%b exp=%b", ctl, RUNV); end
        vectors++;
        if (hif.stall_cycles !== 16'd1) begin
            errors++; $display("FAIL load_use_cnt got=%0d exp=1", hif.stall_cycles);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_load_branch();
        do_reset();
        set_lw2_in_ex(1'b1);
        hif.br_taken_id = 1'b1;
        #1;
        vectors++;
        if (ctl !== STALLV) begin errors++; $display("FAIL ld_br_stall1 got=%b exp=%b", ctl, STALLV); end
        @(negedge clk);
        hif.rd_ex = 5'd0; hif.memread_ex = 1'b0; hif.regwrite_ex = 1'b0;
        hif.rd_mem = 5'd2; hif.memread_mem = 1'b1;
        #1;
        vectors++;
        if (ctl !== STALLV) begin errors++; $display("FAIL ld_br_stall2 got=%b exp=%b", ctl, STALLV); end
        @(negedge clk);
        hif.rd_mem = 5'd0; hif.memread_mem = 1'b0; hif.br_taken_id = 1'b0;
        #1;
        vectors++;
        if (ctl !== RUNV) begin errors++; $display("FAIL ld_br_run got=%b exp=%b", ctl, RUNV); end
        vectors++;
        if (hif.stall_cycles !== 16'd2 || hif.flush_cycles !== 16'd0) begin
            errors++;
            $display("FAIL ld_br_cnt got=%0d/%0d exp=2/0", hif.stall_cycles, hif.flush_cycles);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_alu_branch_flush();
        do_reset();
        hif.rd_ex = 5'd4; hif.regwrite_ex = 1'b1;
        hif.rs_id = 5'd4; hif.use_rs = 1'b1; hif.is_branch_id = 1'b1; hif.br_taken_id = 1'b1;
        #1;
        vectors++;
        if (ctl !== STALLV) begin errors++; $display("FAIL alu_br_stall got=%b exp=%b", ctl, STALLV); end
        @(negedge clk);
        hif.rd_ex = 5'd0; hif.regwrite_ex = 1'b0; hif.rd_mem = 5'd4;
        #1;
        vectors++;
        if (ctl !== FLUSHV) begin errors++; $display("FAIL alu_br_flush got=%b exp=%b", ctl, FLUSHV); end
        vectors++;
        if (hif.stall_cycles !== 16'd1) begin
            errors++; $display("FAIL alu_br_stall_cnt got=%0d exp=1", hif.stall_cycles);
        end
        @(negedge clk);
        idle();
        #1;
        vectors++;
        if (ctl !== RUNV || hif.flush_cycles !== 16'd1) begin
            errors++; $display("FAIL alu_br_after got=%b/%0d exp=%b/1", ctl, hif.flush_cycles, RUNV);
        end
        @(negedge clk);
    endtask

    task automatic test_match_edges();
        do_reset();
        hif.memread_ex = 1'b1; hif.regwrite_ex = 1'b1; hif.rd_ex = 5'd0;
        hif.rs_id = 5'd0; hif.use_rs = 1'b1; hif.is_branch_id = 1'b1;
        #1;
        vectors++;
        if (ctl !== RUNV) begin errors++; $display("FAIL zero_reg got=%b exp=%b", ctl, RUNV); end
        hif.is_branch_id = 1'b0;
        hif.rd_ex = 5'd5; hif.rs_id = 5'd5; hif.use_rs = 1'b0; hif.rt_id = 5'd6; hif.use_rt = 1'b1;
        #1;
        vectors++;
        if (ctl !== RUNV) begin errors++; $display("FAIL unused_rs got=%b exp=%b", ctl, RUNV); end
        hif.rt_id = 5'd5;
        #1;
        vectors++;
        if (ctl !== STALLV) begin errors++; $display("FAIL rt_match got=%b exp=%b", ctl, STALLV); end
        hif.regwrite_ex = 1'b1; hif.memread_ex = 1'b0;
        #1;
        vectors++;
        if (ctl !== RUNV) begin errors++; $display("FAIL alu_nonbranch got=%b exp=%b", ctl, RUNV); end
        idle();
        @(negedge clk);
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_lw2_in_ex(1'b1);
        #1;
        vectors++;
        if (ctl !== STALLV) begin errors++; $display("FAIL mw_stall1 got=%b exp=%b", ctl, STALLV); end
        @(negedge clk);
        hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (ctl !== FREEZEV) begin
                errors++; $display("FAIL mw_freeze%0d got=%b exp=%b", i, ctl, FREEZEV);
            end
            @(negedge clk);
        end
        hif.mem_ready = 1'b1;
        #1;
        vectors++;
        if (ctl !== STALLV) begin errors++; $display("FAIL mw_resume got=%b exp=%b", ctl, STALLV); end
        @(negedge clk);
        idle();
        #1;
        vectors++;
        if (ctl !== RUNV || hif.stall_cycles !== 16'd5) begin
            errors++; $display("FAIL mw_done got=%b/%0d exp=%b/5", ctl, hif.stall_cycles, RUNV);
        end
        hif.jump_id = 1'b1; hif.mem_req = 1'b1;
        #1;
        vectors++;
        if (ctl !== FREEZEV) begin errors++; $display("FAIL mw_over_flush got=%b exp=%b", ctl, FREEZEV); end
        @(negedge clk);
        hif.mem_ready = 1'b1;
        #1;
        vectors++;
        if (ctl !== FLUSHV) begin errors++; $display("FAIL mw_then_flush got=%b exp=%b", ctl, FLUSHV); end
        @(negedge clk);
        idle();
        #1;
        vectors++;
        if (hif.stall_cycles !== 16'd6 || hif.flush_cycles !== 16'd1) begin
            errors++;
            $display("FAIL mw_cnt got=%0d/%0d exp=6/1", hif.stall_cycles, hif.flush_cycles);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_reset();
        hif.jump_id = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (ctl !== FLUSHV) begin errors++; $display("FAIL b2b_flush%0d got=%b exp=%b", i, ctl, FLUSHV); end
            @(negedge clk);
        end
        idle();
        set_lw2_in_ex(1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (ctl !== STALLV) begin errors++; $display("FAIL b2b_stall%0d got=%b exp=%b", i, ctl, STALLV); end
            @(negedge clk);
        end
        idle();
        #1;
        vectors++;
        if (hif.stall_cycles !== 16'd2 || hif.flush_cycles !== 16'd2) begin
            errors++;
            $display("FAIL b2b_cnt got=%0d/%0d exp=2/2", hif.stall_cycles, hif.flush_cycles);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        set_lw2_in_ex(1'b1);
        @(negedge clk);
        idle();
        #1;
        vectors++;
        if (ctl !== STALLV) begin errors++; $display("FAIL ar_in_stall got=%b exp=%b", ctl, STALLV); end
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (ctl !== RUNV) begin errors++; $display("FAIL ar_ctl got=%b exp=%b", ctl, RUNV); end
        vectors++;
        if (hif.stall_cycles !== 16'd0) begin
            errors++; $display("FAIL ar_cnt got=%0d exp=0", hif.stall_cycles);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (ctl !== RUNV) begin errors++; $display("FAIL ar_after got=%b exp=%b", ctl, RUNV); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        do_reset();
        hsat.rd_ex = 5'd2; hsat.memread_ex = 1'b1; hsat.rs_id = 5'd2; hsat.use_rs = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1;
        vectors++;
        if (hsat.stall_cycles !== 2'd3) begin
            errors++; $display("FAIL sat_reach got=%0d exp=3", hsat.stall_cycles);
        end
        for (int i = 0; i < 2; i++) @(negedge clk);
        #1;
        vectors++;
        if (hsat.stall_cycles !== 2'd3) begin
            errors++; $display("FAIL sat_hold got=%0d exp=3", hsat.stall_cycles);
        end
        idle();
        hsat.jump_id = 1'b1;
        for (int i = 0; i < 2; i++) @(negedge clk);
        #1;
        vectors++;
        if (hsat.flush_cycles !== 2'd2) begin
            errors++; $display("FAIL sat_flush_mid got=%0d exp=2", hsat.flush_cycles);
        end
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1;
        vectors++;
        if (hsat.flush_cycles !== 2'd3) begin
            errors++; $display("FAIL sat_flush got=%0d exp=3", hsat.flush_cycles);
        end
        idle();
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_branch_flush();
        test_match_edges();
        test_mem_wait();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
